encoder_serial: RTL and testbench

ENCODER_SERIAL -- requirements
Module: encoder_serial

---
 rtl/encoder_serial.sv | 111 +++++++++++
 tb/tb_encoder_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_serial.sv
// Serial priority encoder: accepts a 4-line request vector and emits the index
// of every active line, lowest first, one code per out_valid/out_ready handshake.
module encoder_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:3] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic       out_last,
    output logic       zero_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [0:3] pending_q, pending_d;
    logic       zero_err_q, zero_err_d;
    logic [1:0] code_s;
    logic       last_s;
    logic       busy_s;
    logic       hs_s;

    function automatic logic [1:0] lowest_index(input logic [0:3] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [0:3] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Next-state, pending-line bookkeeping and output decode
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        busy_s     = (state_q == BUSY);
        code_s     = lowest_index(pending_q);
        last_s     = busy_s && single_bit(pending_q);
        hs_s       = busy_s && out_ready;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != 4'b0000) begin
                        pending_d = in_vec;
                        state_d   = BUSY;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end else begin
                    zero_err_d = 1'b0;
                end
            end
            BUSY: begin
                // Request inputs are deliberately ignored here; no second vector is buffered.
                if (hs_s) begin
                    pending_d[code_s] = 1'b0;
                    if (last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    pending_d = pending_q;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 4'b0000;
            end
        endcase

        in_ready  = (state_q == IDLE) && !rst;
        out_valid = busy_s;
        out_code  = busy_s ? code_s : 2'b00;
        out_last  = last_s;
        zero_err  = zero_err_q;
    end

    // State, pending lines and zero-vector flag; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 4'b0000;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_encoder_serial.sv
// Directed bench for encoder_serial: one-hot, multi-hot, backpressure, zero
// vector, mid-operation reset and a decoder round trip over all nonzero vectors.
module tb_encoder_serial;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [0:3] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_last;
    logic       zero_err;

    int tests_run;
    int tests_failed;

    encoder_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:3] vec;
        logic [0:3] rem;
        logic [0:3] dec;
        logic [1:0] exp_code;
        int         ones;
        logic [1:0] mh_codes [3];
        logic       mh_last  [3];

        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 4'b0000;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_zero_err", 32'(zero_err), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // One-hot sweep
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec = 4'b1000 >> i;
            in_valid = 1'b1;
            in_vec   = vec;
            tick();
            in_valid = 1'b0;
            check("onehot_valid", 32'(out_valid), 32'd1);
            check("onehot_code", 32'(out_code), 32'(i));
            check("onehot_last", 32'(out_last), 32'd1);
            check("onehot_busy_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("onehot_idle_valid", 32'(out_valid), 32'd0);
            check("onehot_idle_in_ready", 32'(in_ready), 32'd1);
        end

        // Multi-hot 1011: lines 0, 2, 3
        mh_codes[0] = 2'd0; mh_codes[1] = 2'd2; mh_codes[2] = 2'd3;
        mh_last[0]  = 1'b0; mh_last[1]  = 1'b0; mh_last[2]  = 1'b1;
        in_valid = 1'b1;
        in_vec   = 4'b1011;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("multi_valid", 32'(out_valid), 32'd1);
            check("multi_code", 32'(out_code), 32'(mh_codes[k]));
            check("multi_last", 32'(out_last), 32'(mh_last[k]));
            tick();
        end
        check("multi_done_in_ready", 32'(in_ready), 32'd1);
        check("multi_done_valid", 32'(out_valid), 32'd0);

        // Backpressure with in_vec changing while busy
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_vec    = 4'b1100;
        tick();
        in_vec = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_code", 32'(out_code), 32'd0);
            check("bp_hold_last", 32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_rel_code0", 32'(out_code), 32'd0);
        check("bp_rel_last0", 32'(out_last), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_rel_code1", 32'(out_code), 32'd1);
        check("bp_rel_last1", 32'(out_last), 32'd1);
        tick();
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_in_ready", 32'(in_ready), 32'd1);

        // Zero vector
        in_valid = 1'b1;
        in_vec   = 4'b0000;
        tick();
        in_valid = 1'b0;
        check("zero_err_pulse", 32'(zero_err), 32'd1);
        check("zero_out_valid", 32'(out_valid), 32'd0);
        check("zero_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("zero_err_clear", 32'(zero_err), 32'd0);

        // Reset mid-operation, asserted together with a pending handshake
        in_valid = 1'b1;
        in_vec   = 4'b1111;
        tick();
        in_valid = 1'b0;
        check("rmid_code0", 32'(out_code), 32'd0);
        tick();
        check("rmid_code1_pre", 32'(out_code), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        check("rmid_in_ready_rst", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check("rmid_valid", 32'(out_valid), 32'd0);
        check("rmid_code", 32'(out_code), 32'd0);
        check("rmid_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        #1;
        check("rmid_in_ready_rel", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rmid_no_code", 32'(out_valid), 32'd0);
        end

        // Decoder round trip over all nonzero vectors
        out_ready = 1'b1;
        for (int v = 1; v < 16; v++) begin
            vec      = 4'(v);
            in_valid = 1'b1;
            in_vec   = vec;
            tick();
            in_valid = 1'b0;
            rem = vec;
            for (int k = 0; k < 4; k++) begin
                if (rem != 4'b0000) begin
                    exp_code = 2'd0;
                    ones     = 0;
                    for (int j = 3; j >= 0; j--) begin
                        if (rem[j]) begin
                            exp_code = 2'(j);
                            ones++;
                        end
                    end
                    dec = 4'b0000;
                    dec[out_code] = 1'b1;
                    check("rt_valid", 32'(out_valid), 32'd1);
                    check("rt_decoded_in_vec", 32'((dec & vec) != 4'b0000), 32'd1);
                    check("rt_code", 32'(out_code), 32'(exp_code));
                    check("rt_last", 32'(out_last), 32'(ones == 1));
                    rem[exp_code] = 1'b0;
                    tick();
                end
            end
            check("rt_done_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
